// File: rtl/router_pkt_src_if.sv
// Byte-stream bundle between a packet requester, the packet source and the router.
// The master side is the packet source; the slave side requests packets and models the router.
interface router_pkt_src_if;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] seed;
  logic       err_inject;
  logic       busy;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       active;
  logic       done;
  logic       illegal;

  modport master (
    input  start, dest_addr, payload_len, seed, err_inject, busy,
    output data_out, pkt_valid, active, done, illegal
  );

  modport slave (
    output start, dest_addr, payload_len, seed, err_inject, busy,
    input  data_out, pkt_valid, active, done, illegal
  );
endinterface

// File: rtl/router_pkt_src.sv
// Packet source for the router: emits header, incrementing payload and an XOR parity byte,
// stalling on router back-pressure. All outputs are registered.
module router_pkt_src (
  input  logic               clock,
  input  logic               resetn,
  router_pkt_src_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PARITY  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] data_q;
  logic       pkt_valid_q;
  logic       active_q;
  logic       done_q;
  logic       illegal_q;
  logic [7:0] parity_q;
  logic [5:0] cnt_q;
  logic [5:0] len_q;
  logic [7:0] seed_q;
  logic       err_q;

  logic       req_illegal;
  logic [7:0] parity_next;

  assign req_illegal = (bus.dest_addr == 2'd3) || (bus.payload_len == 6'd0);
  // Running parity including the byte currently on the bus, used when that byte is accepted.
  assign parity_next = parity_q ^ data_q;

  assign bus.data_out  = data_q;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.active    = active_q;
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;

  // NOTE: every register here, including the latched request fields, is reset so that an
  // aborted packet leaves no stale length, seed or parity behind; sequential state uses <= only
  // so that all right-hand sides see pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      data_q      <= 8'h00;
      pkt_valid_q <= 1'b0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      parity_q    <= 8'h00;
      cnt_q       <= 6'd0;
      len_q       <= 6'd0;
      seed_q      <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (req_illegal) begin
              illegal_q <= 1'b1;
            end else begin
              len_q       <= bus.payload_len;
              seed_q      <= bus.seed;
              err_q       <= bus.err_inject;
              parity_q    <= 8'h00;
              cnt_q       <= 6'd0;
              data_q      <= {bus.payload_len, bus.dest_addr};
              pkt_valid_q <= 1'b1;
              active_q    <= 1'b1;
              state       <= HEADER;
            end
          end
        end

        HEADER: begin
          if (!bus.busy) begin
            parity_q <= parity_next;
            data_q   <= seed_q;
            cnt_q    <= 6'd0;
            state    <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (!bus.busy) begin
            parity_q <= parity_next;
            if (cnt_q == len_q - 6'd1) begin
              data_q      <= parity_next ^ {7'd0, err_q};
              pkt_valid_q <= 1'b0;
              state       <= PARITY;
            end else begin
              cnt_q  <= cnt_q + 6'd1;
              data_q <= data_q + 8'd1;
            end
          end
        end

        PARITY: begin
          if (!bus.busy) begin
            data_q   <= 8'h00;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          data_q      <= 8'h00;
          pkt_valid_q <= 1'b0;
          active_q    <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_src.sv
// Self-checking bench for router_pkt_src: directed vector table, hand-written corner
// sequences and randomized packets checked cycle by cycle against an expected byte list.
module tb_router_pkt_src;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_pkt_src_if bus ();

  router_pkt_src dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] dest;
    logic [5:0] len;
    logic [7:0] seed;
    logic       err;
    int         busy_mode;   // 0 never busy, 1 random busy, 2 three-cycle stall at stall_k
    int         stall_k;
    logic       exp_illegal;
    logic [7:0] exp_hdr;
    logic [7:0] exp_par;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Observed output word: {data_out, pkt_valid, active, done, illegal}
  function automatic logic [11:0] obs();
    return {bus.data_out, bus.pkt_valid, bus.active, bus.done, bus.illegal};
  endfunction

  function automatic logic [11:0] pack(input logic [7:0] d, input logic pv, input logic a,
                                       input logic dn, input logic il);
    return {d, pv, a, dn, il};
  endfunction

  function automatic logic [7:0] payload_byte(input logic [7:0] seed, input int i);
    return 8'((int'(seed) + i) % 256);
  endfunction

  function automatic logic [7:0] model_parity(input logic [1:0] dest, input logic [5:0] len,
                                              input logic [7:0] seed, input logic err);
    logic [7:0] p;
    p = {len, dest};
    for (int i = 0; i < int'(len); i++) p = p ^ payload_byte(seed, i);
    if (err) p = p ^ 8'h01;
    return p;
  endfunction

  task automatic drive_idle();
    bus.start       = 1'b0;
    bus.dest_addr   = 2'd0;
    bus.payload_len = 6'd0;
    bus.seed        = 8'h00;
    bus.err_inject  = 1'b0;
    bus.busy        = 1'b0;
  endtask

  task automatic launch(input logic [1:0] dest, input logic [5:0] len,
                        input logic [7:0] seed, input logic err);
    bus.start       = 1'b1;
    bus.dest_addr   = dest;
    bus.payload_len = len;
    bus.seed        = seed;
    bus.err_inject  = err;
    bus.busy        = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  // Starts with the header on the bus; walks the whole packet, scrambling the request
  // inputs every cycle, and ends one cycle after the done pulse.
  task automatic follow_packet(input string tag, input logic [7:0] hdr, input logic [5:0] len,
                               input logic [7:0] seed, input logic [7:0] par,
                               input int busy_mode, input int stall_k, input bit start_at_done);
    logic [7:0] exp_q[$];
    int         k;
    int         cyc;
    int         stall_left;
    logic       b;
    exp_q.push_back(hdr);
    for (int i = 0; i < int'(len); i++) exp_q.push_back(payload_byte(seed, i));
    exp_q.push_back(par);
    k = 0;
    cyc = 0;
    stall_left = 3;
    while (k < exp_q.size()) begin
      if (cyc > 1000) begin
        check({tag, " timeout"}, 32'(k), 32'(exp_q.size()));
        drive_idle();
        return;
      end
      check({tag, " byte"}, 32'(obs()), 32'(pack(exp_q[k], k < exp_q.size() - 1, 1'b1, 1'b0, 1'b0)));
      b = 1'b0;
      if (busy_mode == 1) b = ($urandom_range(0, 3) == 0);
      else if (busy_mode == 2 && k == stall_k && stall_left > 0) begin
        b = 1'b1;
        stall_left--;
      end
      bus.busy        = b;
      bus.start       = 1'($urandom);
      bus.dest_addr   = 2'($urandom);
      bus.payload_len = 6'($urandom);
      bus.seed        = 8'($urandom);
      bus.err_inject  = 1'($urandom);
      tick();
      cyc++;
      if (!b) k++;
    end
    drive_idle();
    check({tag, " done"}, 32'(obs()), 32'(pack(8'h00, 1'b0, 1'b0, 1'b1, 1'b0)));
    if (start_at_done) begin
      bus.start       = 1'b1;
      bus.dest_addr   = 2'd2;
      bus.payload_len = 6'd2;
      bus.seed        = 8'h33;
    end
    tick();
    check({tag, " after done"}, 32'(obs()), 32'(pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
  endtask

  task automatic illegal_req(input string tag, input logic [1:0] dest, input logic [5:0] len,
                             input logic [7:0] seed);
    launch(dest, len, seed, 1'b0);
    check({tag, " pulse"}, 32'(obs()), 32'(pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b1)));
    tick();
    check({tag, " clear"}, 32'(obs()), 32'(pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
  endtask

  initial begin
    vecs[0] = '{2'd1, 6'd3,  8'h10, 1'b0, 0, 0, 1'b0, 8'h0D, 8'h1E};
    vecs[1] = '{2'd1, 6'd3,  8'h10, 1'b1, 0, 0, 1'b0, 8'h0D, 8'h1F};
    vecs[2] = '{2'd1, 6'd3,  8'h10, 1'b0, 2, 2, 1'b0, 8'h0D, 8'h1E};
    vecs[3] = '{2'd2, 6'd63, 8'hF0, 1'b0, 0, 0, 1'b0, 8'hFE, 8'hD1};
    vecs[4] = '{2'd3, 6'd5,  8'h00, 1'b0, 0, 0, 1'b1, 8'h00, 8'h00};
    vecs[5] = '{2'd0, 6'd0,  8'h22, 1'b0, 0, 0, 1'b1, 8'h00, 8'h00};
    vecs[6] = '{2'd0, 6'd1,  8'hFF, 1'b1, 1, 0, 1'b0, 8'h04, 8'hFA};

    drive_idle();
    resetn = 1'b0;
    #2;
    check("reset state", 32'(obs()), 32'(pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
    tick();
    tick();
    #2 resetn = 1'b1;
    tick();
    check("idle after reset", 32'(obs()), 32'(pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));

    foreach (vecs[i]) begin
      if (vecs[i].exp_illegal) begin
        illegal_req($sformatf("vec%0d illegal", i), vecs[i].dest, vecs[i].len, vecs[i].seed);
      end else begin
        launch(vecs[i].dest, vecs[i].len, vecs[i].seed, vecs[i].err);
        follow_packet($sformatf("vec%0d", i), vecs[i].exp_hdr, vecs[i].len, vecs[i].seed,
                      vecs[i].exp_par, vecs[i].busy_mode, vecs[i].stall_k, 1'b0);
      end
    end

    // Start held during the done cycle is ignored; the next packet begins one cycle later.
    launch(2'd0, 6'd2, 8'h80, 1'b0);
    follow_packet("back2back a", 8'h08, 6'd2, 8'h80, model_parity(2'd0, 6'd2, 8'h80, 1'b0),
                  0, 0, 1'b1);
    tick();
    bus.start = 1'b0;
    follow_packet("back2back b", 8'h0A, 6'd2, 8'h33, model_parity(2'd2, 6'd2, 8'h33, 1'b0),
                  0, 0, 1'b0);

    // Reset while payload is in flight: outputs clear at once, no done, clean restart.
    launch(2'd1, 6'd10, 8'h40, 1'b0);
    tick();
    tick();
    check("mid payload", 32'(obs()), 32'(pack(8'h41, 1'b1, 1'b1, 1'b0, 1'b0)));
    #1 resetn = 1'b0;
    #1 check("async reset", 32'(obs()), 32'(pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
    tick();
    #2 resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no done after abort", 32'(obs()), 32'(pack(8'h00, 1'b0, 1'b0, 1'b0, 1'b0)));
    end
    launch(2'd1, 6'd10, 8'h40, 1'b0);
    follow_packet("post reset", 8'h29, 6'd10, 8'h40, model_parity(2'd1, 6'd10, 8'h40, 1'b0),
                  1, 0, 1'b0);

    // Randomized packets with random back-pressure, plus occasional illegal requests.
    for (int n = 0; n < 25; n++) begin
      logic [1:0] d;
      logic [5:0] l;
      logic [7:0] s;
      logic       e;
      d = 2'($urandom_range(0, 2));
      l = 6'($urandom_range(1, 63));
      s = 8'($urandom);
      e = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        if ($urandom_range(0, 1) == 0) illegal_req("rand illegal dest", 2'd3, l, s);
        else                           illegal_req("rand illegal len", d, 6'd0, s);
      end else begin
        launch(d, l, s, e);
        follow_packet($sformatf("rand%0d", n), {l, d}, l, s, model_parity(d, l, s, e),
                      1, 0, 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
